// File: rtl/ara_tohost_monitor.sv
// Passive AXI write snooper: pairs AW/W handshakes in order and latches the tohost exit word,
// with a run-cycle counter, optional timeout exit and sticky pending-FIFO overflow flag.

module ara_tohost_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head_c,
    output logic             empty_c,
    output logic             full_c
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW:0]      wr_ptr_q;
    logic [PtrW:0]      rd_ptr_q;
    logic [Width-1:0]   mem_q [Depth];
    logic               push_ok;

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok = push && (!full_c || pop);
    assign head_c  = mem_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data;
    end
endmodule

module ara_tohost_monitor #(
    parameter int unsigned              AxiAddrWidth  = 64,
    parameter int unsigned              AxiDataWidth  = 256,
    parameter logic [AxiAddrWidth-1:0]  TohostAddr    = AxiAddrWidth'(64'h8000_0000),
    parameter int unsigned              NumPending    = 4,
    parameter logic [63:0]              TimeoutCycles = 64'd0,
    parameter logic [62:0]              TimeoutCode   = 63'hDEAD
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      aw_valid_i,
    input  logic                      aw_ready_i,
    input  logic [AxiAddrWidth-1:0]   aw_addr_i,
    input  logic                      w_valid_i,
    input  logic                      w_ready_i,
    input  logic [AxiDataWidth-1:0]   w_data_i,
    input  logic [AxiDataWidth/8-1:0] w_strb_i,
    input  logic                      w_last_i,
    output logic [63:0]               exit_o,
    output logic [63:0]               cycle_cnt_o,
    output logic                      error_o
);
    localparam int unsigned NumLanes = AxiDataWidth / 64;
    localparam int unsigned LaneSel  = 32'((TohostAddr >> 3) & AxiAddrWidth'(NumLanes - 1));

    typedef enum logic {IDLE, DONE} state_e;

    state_e        state_q, state_d;
    logic [63:0]   exit_d, cnt_d;
    logic          error_d;
    logic          first_q;
    logic          aw_hs, w_hs, w_push, aw_match, pop;
    logic          aw_head, aw_empty, aw_full;
    logic [63:0]   w_head;
    logic          w_empty, w_full;
    logic [63:0]   lane_data, lane_word;
    logic [7:0]    lane_strb;
    logic          unused_bits;

    assign aw_hs    = aw_valid_i & aw_ready_i;
    assign w_hs     = w_valid_i & w_ready_i;
    assign w_push   = w_hs & first_q;
    assign aw_match = (aw_addr_i[AxiAddrWidth-1:3] == TohostAddr[AxiAddrWidth-1:3]);
    assign pop      = !aw_empty && !w_empty;

    assign lane_data   = w_data_i[LaneSel*64 +: 64];
    assign lane_strb   = w_strb_i[LaneSel*8 +: 8];
    assign unused_bits = ^{aw_addr_i[2:0], w_data_i, w_strb_i};

    // Strobe-masked tohost lane of the current beat
    always_comb begin
        lane_word = '0;
        for (int b = 0; b < 8; b++) begin
            lane_word[b*8 +: 8] = lane_strb[b] ? lane_data[b*8 +: 8] : 8'h00;
        end
    end

    ara_tohost_fifo #(.Depth(NumPending), .Width(1)) u_aw_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (aw_hs),
        .push_data (aw_match),
        .pop       (pop),
        .head_c    (aw_head),
        .empty_c   (aw_empty),
        .full_c    (aw_full)
    );

    ara_tohost_fifo #(.Depth(NumPending), .Width(64)) u_w_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (w_push),
        .push_data (lane_word),
        .pop       (pop),
        .head_c    (w_head),
        .empty_c   (w_empty),
        .full_c    (w_full)
    );

    // Next state: a tohost pair takes priority over the timeout in the same cycle
    always_comb begin
        state_d = state_q;
        exit_d  = exit_o;
        cnt_d   = cycle_cnt_o;
        error_d = error_o | (aw_hs && aw_full && !pop) | (w_push && w_full && !pop);
        if (state_q == IDLE) begin
            if (cycle_cnt_o != '1) cnt_d = cycle_cnt_o + 64'd1;
            if (pop && aw_head && w_head[0]) begin
                exit_d  = w_head;
                state_d = DONE;
            end else if (TimeoutCycles != 64'd0 && cycle_cnt_o == TimeoutCycles - 64'd1) begin
                exit_d  = {TimeoutCode, 1'b1};
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            exit_o      <= '0;
            cycle_cnt_o <= '0;
            error_o     <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            exit_o      <= exit_d;
            cycle_cnt_o <= cnt_d;
            error_o     <= error_d;
            if (w_hs) first_q <= w_last_i;
        end
    end
endmodule
